clk_rst_sequencer: RTL and testbench
====================================

# clk_rst_sequencer

Power-up and clock-gating sequencer that sits directly upstream of the clock/reset generator. It runs on the non-gated SoC clock and consumes the clock manager's `locked` flag. It produces the SoC/cluster clock-enable inputs and the sequenced active-low SoC/cluster resets that the generator forwards. It also runs a 4-phase request/acknowledge handshake through which software gates the cluster clock once the cluster is idle.

## Interface
Parameters:
- `LOCK_FILTER_CYCLES`, 16: consecutive synchronized `locked` high cycles required before start-up.
- `CLK_EN_DELAY`, 4: cycles a clock runs, with its reset still held, before the next step.
- `RST_HOLD_CYCLES`, 8: cycles between SoC reset release and cluster reset release.

Ports:
- `clk_i` in 1: non-gated SoC clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `locked_i` in 1: clock-manager lock, asynchronous to `clk_i`.
- `cluster_gate_req_i` in 1: software request to gate the cluster clock (level).
- `cluster_busy_i` in 1: cluster not idle; blocks gating.
- `cluster_gate_ack_o` out 1: gating acknowledge.
- `clk_soc_enable_o` out 1: SoC clock enable.
- `clk_cluster_enable_o` out 1: cluster clock enable.
- `rstn_soc_o` out 1: SoC reset, active-low.
- `rstn_cluster_o` out 1: cluster reset, active-low.
- `ready_o` out 1: sequence complete, in RUN state.
- `state_o` out 3: current state encoding, for debug.

## Operation
- `locked_i` passes through a 2-flop synchronizer; the result is `lock_s`. All other inputs are synchronous to `clk_i`.
- A single down-counter serves all waits. Its width is `$clog2(max(params))+1`. It is loaded on entry to each timed state.
- IDLE (0): all outputs 0.
  - The counter counts consecutive `lock_s`=1 cycles.
  - `lock_s`=0 clears the count.
  - After `LOCK_FILTER_CYCLES` consecutive high cycles, go to CLK_ON.
- CLK_ON (1): both clock enables = 1, both resets held low. After `CLK_EN_DELAY` cycles, go to RST_REL.
- RST_REL (2): `rstn_soc_o`=1, `rstn_cluster_o`=0. After `RST_HOLD_CYCLES` cycles, go to RUN.
- RUN (3): everything enabled and released, `ready_o`=1.
  - `cluster_gate_req_i`=1 and `cluster_busy_i`=0: go to GATED.
  - `cluster_gate_req_i`=1 and `cluster_busy_i`=1: stay in RUN until busy falls.
- GATED (4): `clk_cluster_enable_o`=0, `cluster_gate_ack_o`=1. Resets stay released; `ready_o`=1. `cluster_gate_req_i`=0: go to UNGATE.
- UNGATE (5): `clk_cluster_enable_o`=1, `cluster_gate_ack_o` still 1.
  - After `CLK_EN_DELAY` cycles, go to RUN; ack falls.
  - A new request during UNGATE is not serviced until RUN.
- Lock loss: `lock_s`=0 in any state other than IDLE forces IDLE on the next edge.
  - All outputs return to 0 on that edge.
  - The counter is cleared.
  - Any handshake in progress is aborted and ack drops.
- Encodings 6 and 7 are unreachable and decode to IDLE.

## Timing
- All outputs are registered and change on the same edge as the state transition they belong to.
- Reset (`rst_i`=1, asynchronous): state IDLE, counter 0, synchronizer flops 0. Every output is 0, including `state_o`=0.
- Latency from `locked_i` rising before edge 0, with defaults:
  - `lock_s`=1 from edge 2.
  - CLK_ON at edge 18: enables = 1.
  - RST_REL at edge 22: `rstn_soc_o`=1.
  - RUN at edge 30: `rstn_cluster_o`=1, `ready_o`=1.
- Gating: request seen at edge N with busy=0 gives enable=0 and ack=1 at edge N+1.
- Ungating: request drop seen at edge M gives enable=1 at edge M+1 and ack=0 at edge M+1+`CLK_EN_DELAY`.
- Lock loss and gate request in the same cycle: lock loss wins.
- `rst_i` asserted mid-sequence: outputs clear immediately, asynchronously. The full sequence reruns after deassertion.

## Structure
- `clk_rst_seq_pkg` holds the `seq_state_e` enum (3-bit, values 0–5), its state encodings, and the default parameter constants.
- One sub-module, `cdc_sync_2ff`: a 2-flop synchronizer with asynchronous active-high reset and reset value 0. It is instantiated for `locked_i`.

## Test plan
- Power-up: `locked_i` rises before edge 0 and stays high. Enables rise at edge 18, `rstn_soc_o` at edge 22, `rstn_cluster_o` and `ready_o` at edge 30; `state_o` steps 0→1→2→3.
- Lock glitch: `locked_i` high for 10 cycles, low for 1, then high. The filter restarts and enables rise 18 edges after the second rise.
- Gating with busy: in RUN, raise req with busy=1 for 5 cycles, then drop busy at edge K. Enable and ack are unchanged until edge K+1, then enable=0 and ack=1.
- Ungate: drop req at edge M. Enable=1 at edge M+1, ack=0 and state RUN at edge M+5. A req re-raised at edge M+2 is serviced only after edge M+5.
- Lock loss in GATED: drop `locked_i`. Two edges later (synchronizer delay), the next edge returns all outputs to 0 with state IDLE.
- Asynchronous reset mid-RST_REL: `rst_i` pulse clears all outputs without a clock edge. Release followed by locked high repeats the 18/22/30 timing.

Source files
------------

// File: rtl/clk_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_seq_pkg
// Shared types and constants for the power-up / clock-gating sequencer.
//   seq_state_e    : 3-bit sequencer state encoding (0..5 in use, 6/7 unused)
//   seq_out_t      : bundle of the registered control outputs
//   DEF_*          : default timing parameters
//   decode_outputs : output values that belong to a given state
//   max3           : helper used to size the shared wait counter
// -----------------------------------------------------------------------------
package clk_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLK_ON  = 3'd1,
    ST_RST_REL = 3'd2,
    ST_RUN     = 3'd3,
    ST_GATED   = 3'd4,
    ST_UNGATE  = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_LOCK_FILTER_CYCLES = 16;
  localparam int unsigned DEF_CLK_EN_DELAY       = 4;
  localparam int unsigned DEF_RST_HOLD_CYCLES    = 8;

  typedef struct packed {
    logic gate_ack;
    logic clk_soc_en;
    logic clk_cluster_en;
    logic rstn_soc;
    logic rstn_cluster;
    logic ready;
  } seq_out_t;

  // Output values driven while the sequencer sits in state st. Unused
  // encodings fall into the default branch and look exactly like IDLE.
  function automatic seq_out_t decode_outputs(input seq_state_e st);
    seq_out_t o;
    o = '0;
    case (st)
      ST_CLK_ON: begin
        o.clk_soc_en     = 1'b1;
        o.clk_cluster_en = 1'b1;
      end
      ST_RST_REL: begin
        o.clk_soc_en     = 1'b1;
        o.clk_cluster_en = 1'b1;
        o.rstn_soc       = 1'b1;
      end
      ST_RUN: begin
        o.clk_soc_en     = 1'b1;
        o.clk_cluster_en = 1'b1;
        o.rstn_soc       = 1'b1;
        o.rstn_cluster   = 1'b1;
        o.ready          = 1'b1;
      end
      ST_GATED: begin
        o.gate_ack       = 1'b1;
        o.clk_soc_en     = 1'b1;
        o.rstn_soc       = 1'b1;
        o.rstn_cluster   = 1'b1;
        o.ready          = 1'b1;
      end
      ST_UNGATE: begin
        o.gate_ack       = 1'b1;
        o.clk_soc_en     = 1'b1;
        o.clk_cluster_en = 1'b1;
        o.rstn_soc       = 1'b1;
        o.rstn_cluster   = 1'b1;
        o.ready          = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/cdc_sync_2ff.sv
// -----------------------------------------------------------------------------
// cdc_sync_2ff
// Two-flop synchronizer for a single-bit level signal crossing into clk.
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops clear to 0
//   d   : asynchronous input level
//   q   : synchronized level, two clk edges behind d
// -----------------------------------------------------------------------------
module cdc_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// clk_rst_sequencer
// Power-up and cluster clock-gating sequencer feeding the clock/reset
// generator. Runs on the non-gated SoC clock.
//   clk_i                : non-gated SoC clock
//   rst_i                : asynchronous active-high reset
//   locked_i             : clock-manager lock (asynchronous, synchronized here)
//   cluster_gate_req_i   : software level request to gate the cluster clock
//   cluster_busy_i       : cluster not idle, holds off gating
//   cluster_gate_ack_o   : gating acknowledge
//   clk_soc_enable_o     : SoC clock enable
//   clk_cluster_enable_o : cluster clock enable
//   rstn_soc_o           : SoC reset, active-low
//   rstn_cluster_o       : cluster reset, active-low
//   ready_o              : start-up sequence complete
//   state_o              : current state encoding (debug)
//
// Gate handshake (4-phase, level based): software raises req; once the
// sequencer is in RUN and the cluster is not busy, the cluster clock stops
// and ack rises. Software then drops req; the cluster clock restarts and ack
// stays high for CLK_EN_DELAY cycles before falling, which closes the
// handshake. A lock loss aborts the handshake and drops ack immediately.
// -----------------------------------------------------------------------------
module clk_rst_sequencer
  import clk_rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER_CYCLES = DEF_LOCK_FILTER_CYCLES,
  parameter int unsigned CLK_EN_DELAY       = DEF_CLK_EN_DELAY,
  parameter int unsigned RST_HOLD_CYCLES    = DEF_RST_HOLD_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       cluster_gate_req_i,
  input  logic       cluster_busy_i,
  output logic       cluster_gate_ack_o,
  output logic       clk_soc_enable_o,
  output logic       clk_cluster_enable_o,
  output logic       rstn_soc_o,
  output logic       rstn_cluster_o,
  output logic       ready_o,
  output logic [2:0] state_o
);

  localparam int unsigned CNT_MAX = max3(LOCK_FILTER_CYCLES, CLK_EN_DELAY,
                                         RST_HOLD_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  // Timed states count down to zero, so a wait of N cycles loads N-1.
  // IDLE counts up instead: the count is the number of consecutive lock
  // samples already seen, and the Nth one triggers the transition.
  localparam logic [CNT_W-1:0] LOCK_LAST     = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLK_EN_LOAD   = CNT_W'(CLK_EN_DELAY - 1);
  localparam logic [CNT_W-1:0] RST_HOLD_LOAD = CNT_W'(RST_HOLD_CYCLES - 1);

  logic             lock_s;
  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  seq_out_t         out_q;

  cdc_sync_2ff u_lock_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (locked_i),
    .q   (lock_s)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q != ST_IDLE && !lock_s) begin
      // Lock loss dominates everything else, including a gate request.
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!lock_s) begin
            cnt_d = '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_d = ST_CLK_ON;
            cnt_d   = CLK_EN_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_CLK_ON: begin
          if (cnt_q == '0) begin
            state_d = ST_RST_REL;
            cnt_d   = RST_HOLD_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RST_REL: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_RUN: begin
          // A busy cluster simply holds off the request; it stays pending.
          if (cluster_gate_req_i && !cluster_busy_i) begin
            state_d = ST_GATED;
          end
        end
        ST_GATED: begin
          if (!cluster_gate_req_i) begin
            state_d = ST_UNGATE;
            cnt_d   = CLK_EN_LOAD;
          end
        end
        ST_UNGATE: begin
          // Requests are ignored here; a new one is picked up from RUN.
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs update together, so every output changes on
  // the same edge as the transition it belongs to.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= decode_outputs(state_d);
    end
  end

  assign cluster_gate_ack_o   = out_q.gate_ack;
  assign clk_soc_enable_o     = out_q.clk_soc_en;
  assign clk_cluster_enable_o = out_q.clk_cluster_en;
  assign rstn_soc_o           = out_q.rstn_soc;
  assign rstn_cluster_o       = out_q.rstn_cluster;
  assign ready_o              = out_q.ready;
  assign state_o              = state_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clk_rst_sequencer
// Self-checking bench for clk_rst_sequencer with default parameters.
// Edge numbering: "edge 0" is the clock edge just before an input change;
// inputs are driven 1 ns after that edge, outputs are sampled 1 ns after
// each following edge. Observed outputs are packed as
// {state[2:0], ack, soc_en, cluster_en, rstn_soc, rstn_cluster, ready}.
// -----------------------------------------------------------------------------
module tb_clk_rst_sequencer;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       gate_req;
  logic       busy;
  logic       gate_ack;
  logic       soc_en;
  logic       cluster_en;
  logic       rstn_soc;
  logic       rstn_cluster;
  logic       ready;
  logic [2:0] state;

  logic [8:0] out_vec;
  logic [8:0] exp_q[$];
  logic [8:0] exp_v;
  int         checks;
  int         failures;
  int         edge_n;

  assign out_vec = {state, gate_ack, soc_en, cluster_en, rstn_soc,
                    rstn_cluster, ready};

  clk_rst_sequencer dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .locked_i             (locked),
    .cluster_gate_req_i   (gate_req),
    .cluster_busy_i       (busy),
    .cluster_gate_ack_o   (gate_ack),
    .clk_soc_enable_o     (soc_en),
    .clk_cluster_enable_o (cluster_en),
    .rstn_soc_o           (rstn_soc),
    .rstn_cluster_o       (rstn_cluster),
    .ready_o              (ready),
    .state_o              (state)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, edge=%0d", edge_n);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- model
  // Expected output vector for each state, written from the state table.
  function automatic logic [8:0] exp_vec(input int st);
    case (st)
      1:       return {3'd1, 6'b011000};
      2:       return {3'd2, 6'b011100};
      3:       return {3'd3, 6'b011111};
      4:       return {3'd4, 6'b110111};
      5:       return {3'd5, 6'b111111};
      default: return 9'd0;
    endcase
  endfunction

  // Power-up timeline relative to the lock rise: 18 / 22 / 30 edges.
  function automatic int power_state(input int e, input int base);
    if (e < base + 18) return 0;
    if (e < base + 22) return 1;
    if (e < base + 30) return 2;
    return 3;
  endfunction

  // ---------------------------------------------------------------- driver
  task automatic next_edge();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    #3;
    checks++;
    if (out_vec !== 9'd0) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", out_vec, 9'd0);
    end
    repeat (3) next_edge();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_q.push_back(exp_vec(0));
    while (exp_q.size() > 0) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL reset_idle edge=%0d got=%b exp=%b", edge_n, out_vec, exp_v);
      end
    end
  endtask

  // Expects IDLE with locked low for at least two edges; leaves DUT in RUN.
  task automatic test_power_up();
    locked = 1'b1;
    for (int e = 1; e <= 32; e++) exp_q.push_back(exp_vec(power_state(e, 0)));
    for (int e = 1; e <= 32; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL power_up e=%0d got=%b exp=%b", e, out_vec, exp_v);
      end
    end
  endtask

  task automatic test_gate_busy();
    int busy_len;
    busy_len = $urandom_range(5, 8);
    gate_req = 1'b1;
    busy     = 1'b1;
    for (int e = 1; e <= busy_len; e++) exp_q.push_back(exp_vec(3));
    while (exp_q.size() > 0) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL gate_busy_hold edge=%0d got=%b exp=%b", edge_n, out_vec, exp_v);
      end
    end
    // Busy drops at edge K: gating takes effect at K+1.
    busy = 1'b0;
    exp_q.push_back(exp_vec(4));
    exp_q.push_back(exp_vec(4));
    while (exp_q.size() > 0) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL gate_after_busy edge=%0d got=%b exp=%b", edge_n, out_vec, exp_v);
      end
    end
  endtask

  task automatic test_ungate();
    // Request drops at edge M, and is raised again at M+2.
    gate_req = 1'b0;
    for (int e = 1; e <= 6; e++)
      exp_q.push_back(exp_vec(e <= 4 ? 5 : (e == 5 ? 3 : 4)));
    for (int e = 1; e <= 6; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL ungate_rereq e=%0d got=%b exp=%b", e, out_vec, exp_v);
      end
      if (e == 2) gate_req = 1'b1;
    end
    // Plain release back to RUN with no new request.
    gate_req = 1'b0;
    for (int e = 1; e <= 6; e++) exp_q.push_back(exp_vec(e <= 4 ? 5 : 3));
    for (int e = 1; e <= 6; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL ungate_plain e=%0d got=%b exp=%b", e, out_vec, exp_v);
      end
    end
  endtask

  task automatic test_lock_loss();
    gate_req = 1'b1;
    exp_q.push_back(exp_vec(4));
    next_edge();
    exp_v = exp_q.pop_front();
    checks++;
    if (out_vec !== exp_v) begin
      failures++;
      $display("FAIL lock_loss_enter_gated got=%b exp=%b", out_vec, exp_v);
    end
    // Lock drops at edge L with the gate request still high.
    locked = 1'b0;
    for (int e = 1; e <= 4; e++) exp_q.push_back(exp_vec(e <= 2 ? 4 : 0));
    for (int e = 1; e <= 4; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL lock_loss e=%0d got=%b exp=%b", e, out_vec, exp_v);
      end
    end
    gate_req = 1'b0;
  endtask

  task automatic test_lock_glitch();
    // High for 10 cycles, low for 1, high again from edge 11.
    locked = 1'b1;
    for (int e = 1; e <= 43; e++) exp_q.push_back(exp_vec(power_state(e, 11)));
    for (int e = 1; e <= 43; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL lock_glitch e=%0d got=%b exp=%b", e, out_vec, exp_v);
      end
      if (e == 10) locked = 1'b0;
      if (e == 11) locked = 1'b1;
    end
  endtask

  task automatic test_async_reset();
    // Reset hits mid-cycle while in RUN.
    #3;
    rst    = 1'b1;
    locked = 1'b0;
    #1;
    checks++;
    if (out_vec !== 9'd0) begin
      failures++;
      $display("FAIL async_rst_run got=%b exp=%b", out_vec, 9'd0);
    end
    repeat (2) next_edge();
    rst = 1'b0;
    repeat (2) next_edge();
    // Power up again and interrupt during RST_REL.
    locked = 1'b1;
    for (int e = 1; e <= 25; e++) exp_q.push_back(exp_vec(power_state(e, 0)));
    for (int e = 1; e <= 25; e++) begin
      next_edge();
      exp_v = exp_q.pop_front();
      checks++;
      if (out_vec !== exp_v) begin
        failures++;
        $display("FAIL async_rst_prep e=%0d got=%b exp=%b", e, out_vec, exp_v);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec !== 9'd0) begin
      failures++;
      $display("FAIL async_rst_rst_rel got=%b exp=%b", out_vec, 9'd0);
    end
    locked = 1'b0;
    repeat (2) next_edge();
    rst = 1'b0;
    repeat (2) next_edge();
    test_power_up();
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    checks   = 0;
    failures = 0;
    edge_n   = 0;
    rst      = 1'b1;
    locked   = 1'b0;
    gate_req = 1'b0;
    busy     = 1'b0;

    test_reset();
    test_power_up();
    test_gate_busy();
    test_ungate();
    test_lock_loss();
    test_lock_glitch();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
